workload_dispatcher: RTL and testbench
======================================

# workload_dispatcher

Consumes the per-port ready/valid workload streams produced by the data generator: each element is {workload_id, size}. It round-robin arbitrates across ports into a single execution slot. It holds each accepted workload for `size` cycles, then reports its completion. It also checks per-port ID ordering, counts completions, and flags when every port has finished its expected quota. It is the sink stage of the workload test harness.

## Interface
- id_width_p, (required), width of workload_id field
- size_width_p, (required), width of size field
- num_ports_p, (required), number of input streams
- expected_count_p, (required), completions required per port before it is finished
- width_p, id_width_p+size_width_p, input element width; element = {id[width_p-1:size_width_p], size[size_width_p-1:0]}
- port_width_lp, `BSG_SAFE_CLOG2(num_ports_p), port index width
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- v_i  in  num_ports_p  per-port valid
- data_i  in  num_ports_p x width_p  per-port element
- ready_o  out  num_ports_p  per-port ready; at most one bit set
- done_v_o  out  1  one-cycle completion pulse
- done_port_o  out  port_width_lp  port of completed workload
- done_id_o  out  id_width_p  id of completed workload
- all_done_o  out  1  sticky; every port reached expected_count_p
- err_o  out  1  sticky; out-of-order id seen
- cycles_o  out  32  cycles from reset release until all_done_o; saturating

## Operation
- State machine: IDLE, EXEC, REPORT.
- IDLE:
  - ready_o is a one-hot combinational grant. It goes to the first port at or after rr_ptr, in ascending index order with wrap, for which v_i is set and the port is not finished.
  - A port is finished when its completion count equals expected_count_p.
  - ready_o is 0 if there is no eligible requester or all_done_o is set.
- Accept occurs when v_i[g] & ready_o[g] in IDLE. On accept:
  - latch g, id and size;
  - load cnt = (size==0) ? 1 : size;
  - set rr_ptr = (g==num_ports_p-1) ? 0 : g+1;
  - go to EXEC.
- ID check at accept: if id != exp_id[g], set err_o (sticky). The workload is still executed and reported.
- EXEC: ready_o = 0. cnt decrements each cycle. When cnt==1, go to REPORT.
- REPORT:
  - done_v_o = 1, with done_port_o and done_id_o equal to the latched values;
  - comp_cnt[port] += 1 and exp_id[port] += 1 (id wraps modulo 2^id_width_p);
  - next state is IDLE.
- all_done_o is set in the cycle after the last port's comp_cnt reaches expected_count_p. It stays set until reset.
- If expected_count_p == 0, all_done_o is set in the first cycle after reset.
- cycles_o increments every non-reset cycle while all_done_o == 0. It saturates at 2^32-1.
- Data on a non-granted port is ignored and must be held by the producer.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, cnt = 0;
  - all comp_cnt and exp_id = 0;
  - ready_o = 0 during reset, done_v_o = 0, done_port_o = 0, done_id_o = 0;
  - all_done_o = 0, err_o = 0, cycles_o = 0.
- Reset mid-EXEC or mid-REPORT aborts the in-flight workload: no done pulse and no count update.
- Accept at cycle T:
  - EXEC occupies T+1 .. T+max(size,1);
  - done_v_o is high at T+max(size,1)+1;
  - the next accept is possible at T+max(size,1)+2.
- Throughput is one workload per max(size,1)+2 cycles.
- ready_o depends combinationally on v_i, state and rr_ptr only, never on data_i. Upstream v_o is registered, so there is no combinational loop.
- Simultaneous valids in IDLE: exactly one grant, per round-robin from rr_ptr.
- A finished port with v_i high is never granted, and it never blocks other ports.
- The id check compares the full id_width_p bits, and exp_id wraps with id.

## Test plan
- Single port, num_ports_p=1, expected_count_p=3, ids 0,1,2 all with size 1 -> accepts 3 cycles apart, done_id_o 0,1,2, all_done_o set, err_o=0. cycles_o equals the count from reset release to all_done_o set.
- Three ports, all v_i high, expected_count_p=2, size 2 -> grant order 0,1,2,0,1,2 with 4 cycles between accepts; all_done_o after the 6th done_v_o.
- Size 0 on port 0 -> handled as size 1: done_v_o exactly 2 cycles after accept.
- Port 1 sends ids 0,2 -> err_o rises at the second accept and stays set; both workloads are reported with done_id_o 0 and 2.
- Port 0 finished with v_i held high, port 1 still active -> ready_o[0] never asserts and port 1 continues to be granted every 3 cycles (size 1).
- Reset asserted during EXEC of size 5 -> no done_v_o. All outputs return to reset values the next cycle, and the replayed stream from id 0 then passes without error.

Source files
------------

// File: rtl/workload_dispatcher.sv
`timescale 1ns/1ps
// Sink stage of the workload harness: round-robin accepts {id,size} elements from several ports,
// occupies one execution slot for max(size,1) cycles, then reports completion and tracks per-port quotas.
module workload_dispatcher #(
   parameter int id_width_p       = 4,
   parameter int size_width_p     = 4,
   parameter int num_ports_p      = 2,
   parameter int expected_count_p = 1,
   parameter int width_p          = id_width_p + size_width_p,
   parameter int port_width_lp    = (num_ports_p > 1) ? $clog2(num_ports_p) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [num_ports_p-1:0]               v_i,
   input  logic [num_ports_p-1:0][width_p-1:0]  data_i,
   output logic [num_ports_p-1:0]               ready_o,
   output logic                                 done_v_o,
   output logic [port_width_lp-1:0]             done_port_o,
   output logic [id_width_p-1:0]                done_id_o,
   output logic                                 all_done_o,
   output logic                                 err_o,
   output logic [31:0]                          cycles_o
);

   typedef enum logic [1:0] {IDLE, EXEC, REPORT} state_e;

   state_e                    state_q;
   logic [port_width_lp-1:0]  rr_q, port_q;
   logic [id_width_p-1:0]     id_q;
   logic [size_width_p-1:0]   cnt_q;
   logic [31:0]               comp_q [num_ports_p];
   logic [id_width_p-1:0]     exp_q  [num_ports_p];
   logic                      done_v_q, all_done_q, err_q;
   logic [31:0]               cycles_q;

   logic [num_ports_p-1:0]    fin, gnt_d;
   logic [port_width_lp-1:0]  gnt_idx_d;
   logic [id_width_p-1:0]     acc_id_d;
   logic [size_width_p-1:0]   acc_size_d;
   logic                      found;
   logic                      accept;
   int                        idx;

   always_comb begin
      for (int p = 0; p < num_ports_p; p++)
         fin[p] = (comp_q[p] == 32'(expected_count_p));
   end

   // Grant scans from rr_q upward with wrap; finished ports are skipped so they never block others.
   always_comb begin
      gnt_d     = '0;
      gnt_idx_d = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < num_ports_p; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= num_ports_p) idx = idx - num_ports_p;
         if (!found && v_i[idx] && !fin[idx]) begin
            found      = 1'b1;
            gnt_d[idx] = 1'b1;
            gnt_idx_d  = port_width_lp'(idx);
         end
      end
   end

   assign ready_o    = (state_q == IDLE && !all_done_q && !reset_i) ? gnt_d : '0;
   assign accept     = |ready_o;
   assign acc_id_d   = data_i[gnt_idx_d][width_p-1:size_width_p];
   assign acc_size_d = data_i[gnt_idx_d][size_width_p-1:0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         port_q     <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         done_v_q   <= 1'b0;
         all_done_q <= 1'b0;
         err_q      <= 1'b0;
         cycles_q   <= '0;
         for (int p = 0; p < num_ports_p; p++) begin
            comp_q[p] <= '0;
            exp_q[p]  <= '0;
         end
      end else begin
         done_v_q <= 1'b0;
         if (!all_done_q && cycles_q != '1) cycles_q <= cycles_q + 32'd1;
         if (&fin) all_done_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  port_q  <= gnt_idx_d;
                  id_q    <= acc_id_d;
                  cnt_q   <= (acc_size_d == '0) ? size_width_p'(1) : acc_size_d;
                  rr_q    <= (gnt_idx_d == port_width_lp'(num_ports_p - 1)) ? '0 : gnt_idx_d + 1'b1;
                  if (acc_id_d != exp_q[gnt_idx_d]) err_q <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == size_width_p'(1)) begin
                  state_q  <= REPORT;
                  done_v_q <= 1'b1;
               end
            end
            REPORT: begin
               comp_q[port_q] <= comp_q[port_q] + 32'd1;
               exp_q[port_q]  <= exp_q[port_q] + 1'b1;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done_v_o    = done_v_q;
   assign done_port_o = port_q;
   assign done_id_o   = id_q;
   assign all_done_o  = all_done_q;
   assign err_o       = err_q;
   assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_workload_dispatcher.sv
`timescale 1ns/1ps
// Bench for workload_dispatcher: a timeline model (accept cycle -> done cycle) checks a 3-port
// instance every cycle; literal tables pin a 1-port instance and a zero-quota instance.
module tb_workload_dispatcher;
   localparam int N = 3, E = 2, IW = 4, SW = 3, W = IW + SW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst3;
   logic [N-1:0]         v3;
   logic [N-1:0][W-1:0]  d3;
   logic [N-1:0]         rdy3;
   logic                 dv3, ad3, er3;
   logic [1:0]           dp3;
   logic [IW-1:0]        did3;
   logic [31:0]          cy3;

   logic                 rst1;
   logic [0:0]           v1, rdy1, dp1;
   logic [0:0][W-1:0]    d1;
   logic                 dv1, ad1, er1;
   logic [IW-1:0]        did1;
   logic [31:0]          cy1;

   logic [1:0]           v0, rdy0;
   logic [1:0][W-1:0]    d0;
   logic [0:0]           dp0;
   logic                 dv0, ad0, er0;
   logic [IW-1:0]        did0;
   logic [31:0]          cy0;

   workload_dispatcher #(.id_width_p(IW), .size_width_p(SW), .num_ports_p(N), .expected_count_p(E)) dut3 (
      .clk_i(clk), .reset_i(rst3), .v_i(v3), .data_i(d3), .ready_o(rdy3), .done_v_o(dv3),
      .done_port_o(dp3), .done_id_o(did3), .all_done_o(ad3), .err_o(er3), .cycles_o(cy3));

   workload_dispatcher #(.id_width_p(IW), .size_width_p(SW), .num_ports_p(1), .expected_count_p(3)) dut1 (
      .clk_i(clk), .reset_i(rst1), .v_i(v1), .data_i(d1), .ready_o(rdy1), .done_v_o(dv1),
      .done_port_o(dp1), .done_id_o(did1), .all_done_o(ad1), .err_o(er1), .cycles_o(cy1));

   workload_dispatcher #(.id_width_p(IW), .size_width_p(SW), .num_ports_p(2), .expected_count_p(0)) dut0 (
      .clk_i(clk), .reset_i(rst1), .v_i(v0), .data_i(d0), .ready_o(rdy0), .done_v_o(dv0),
      .done_port_o(dp0), .done_id_o(did0), .all_done_o(ad0), .err_o(er0), .cycles_o(cy0));

   int nchk = 0, nerr = 0, cyc = 0;

   // producer tables: per port, items {id,size,earliest cycle}
   int qid [N][8], qsz [N][8], qst [N][8], qn [N], qh [N];
   // timeline model
   int m_comp [N], m_exp [N];
   int m_rr, m_done_at, m_port, m_id, m_errc, m_fin;
   bit m_busy;
   // DUT-observed logs for literal pins
   int acc_p [32], acc_c [32], dn_c [32], dn_id [32];
   int nacc, ndn;

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic add(input int p, input int id, input int sz, input int st);
      qid[p][qn[p]] = id; qsz[p][qn[p]] = sz; qst[p][qn[p]] = st;
      qn[p]++;
   endtask

   task automatic reset3();
      rst3 = 1'b1; v3 = '0; d3 = '0;
      @(posedge clk); #1;
      chk("rst_ready", rdy3, 0);     chk("rst_done_v", dv3, 0);
      chk("rst_done_port", dp3, 0);  chk("rst_done_id", did3, 0);
      chk("rst_all_done", ad3, 0);   chk("rst_err", er3, 0);
      chk("rst_cycles", cy3, 0);
      @(posedge clk); #1;
      rst3 = 1'b0;
      for (int p = 0; p < N; p++) begin
         qn[p] = 0; qh[p] = 0; m_comp[p] = 0; m_exp[p] = 0;
      end
      for (int k = 0; k < 32; k++) begin
         acc_p[k] = -1; acc_c[k] = -1; dn_c[k] = -1; dn_id[k] = -1;
      end
      m_rr = 0; m_busy = 0; m_done_at = -1; m_port = 0; m_id = 0; m_errc = -1; m_fin = -1;
      nacc = 0; ndn = 0; cyc = 0;
   endtask

   task automatic run3(input int n);
      int g, sz;
      bit all, e_ad;
      logic [N-1:0] e_rdy;
      for (int k = 0; k < n; k++) begin
         for (int p = 0; p < N; p++) begin
            if (qh[p] < qn[p] && cyc >= qst[p][qh[p]]) begin
               v3[p] = 1'b1;
               d3[p] = {IW'(qid[p][qh[p]]), SW'(qsz[p][qh[p]])};
            end else begin
               v3[p] = 1'b0;
               d3[p] = '0;
            end
         end
         #1;
         if (m_busy && cyc == m_done_at + 1) begin
            m_comp[m_port]++;
            m_exp[m_port] = (m_exp[m_port] + 1) % 16;
            m_busy = 0;
         end
         if (m_fin < 0) begin
            all = 1;
            for (int p = 0; p < N; p++) if (m_comp[p] != E) all = 0;
            if (all) m_fin = cyc;
         end
         e_ad = (m_fin >= 0 && cyc > m_fin);
         g = -1;
         e_rdy = '0;
         if (!m_busy && !e_ad)
            for (int i = 0; i < N; i++) begin
               int ix;
               ix = (m_rr + i) % N;
               if (g < 0 && v3[ix] && m_comp[ix] != E) g = ix;
            end
         if (g >= 0) e_rdy[g] = 1'b1;
         chk("ready", rdy3, e_rdy);
         chk("done_v", dv3, (m_busy && cyc == m_done_at));
         if (m_busy && cyc == m_done_at) begin
            chk("done_port", dp3, m_port);
            chk("done_id", did3, m_id % 16);
         end
         chk("err", er3, (m_errc >= 0 && cyc > m_errc));
         chk("all_done", ad3, e_ad);
         chk("cycles", cy3, e_ad ? m_fin + 1 : cyc);
         if (g >= 0) begin
            sz = qsz[g][qh[g]];
            m_busy = 1;
            m_done_at = cyc + ((sz == 0) ? 1 : sz) + 1;
            m_port = g;
            m_id = qid[g][qh[g]];
            if ((m_id % 16) != m_exp[g] && m_errc < 0) m_errc = cyc;
            m_rr = (g + 1) % N;
         end
         for (int p = 0; p < N; p++)
            if (rdy3[p] && v3[p]) begin
               if (nacc < 32) begin acc_p[nacc] = p; acc_c[nacc] = cyc; nacc++; end
               qh[p]++;
            end
         if (dv3 && ndn < 32) begin dn_c[ndn] = cyc; dn_id[ndn] = int'(did3); ndn++; end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int exp_order [6];
      exp_order = '{0, 1, 2, 0, 1, 2};
      rst1 = 1'b1; rst3 = 1'b1;
      v1 = '0; d1 = '0; v0 = 2'b11; d0 = '0; v3 = '0; d3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("p1_rst_ready", rdy1, 0); chk("p1_rst_done_v", dv1, 0);
      chk("p1_rst_all_done", ad1, 0); chk("p1_rst_cycles", cy1, 0);
      chk("e0_rst_all_done", ad0, 0);
      rst1 = 1'b0;
      sent = 0;
      for (int c = 0; c < 14; c++) begin
         cyc = c;
         v1[0] = (sent < 3);
         d1[0] = {IW'(sent), SW'(1)};
         #1;
         chk("p1_ready", rdy1, (c == 0 || c == 3 || c == 6));
         chk("p1_done_v", dv1, (c == 2 || c == 5 || c == 8));
         if (c == 2 || c == 5 || c == 8) chk("p1_done_id", did1, (c - 2) / 3);
         chk("p1_all_done", ad1, (c >= 10));
         chk("p1_cycles", cy1, (c < 10) ? c : 10);
         chk("p1_err", er1, 0);
         chk("e0_ready", rdy0, 0);
         chk("e0_all_done", ad0, (c >= 1));
         chk("e0_cycles", cy0, (c < 1) ? c : 1);
         if (rdy1[0] && v1[0]) sent++;
         @(posedge clk); #1;
      end

      // three ports contending, size 2
      reset3();
      for (int p = 0; p < N; p++) begin add(p, 0, 2, 0); add(p, 1, 2, 0); end
      run3(28);
      chk("s1_accepts", nacc, 6);
      for (int k = 0; k < 6; k++) begin
         chk("s1_grant_port", acc_p[k], exp_order[k]);
         chk("s1_grant_cycle", acc_c[k], 4 * k);
      end
      chk("s1_sixth_done", dn_c[5], 23);
      chk("s1_all_done", ad3, 1);
      chk("s1_cycles", cy3, 25);

      // size 0 and id gap
      reset3();
      add(0, 0, 0, 0);
      add(1, 0, 1, 0); add(1, 2, 1, 0);
      run3(12);
      chk("s2_size0_latency", dn_c[0] - acc_c[0], 2);
      chk("s2_id_a", dn_id[1], 0);
      chk("s2_id_b", dn_id[2], 2);
      chk("s2_err", er3, 1);

      // finished port keeps v_i high
      reset3();
      add(0, 0, 1, 0); add(0, 1, 1, 0); add(0, 2, 1, 0);
      add(1, 0, 1, 6); add(1, 1, 1, 6);
      run3(16);
      chk("s3_accepts", nacc, 4);
      chk("s3_port_a", acc_p[2], 1); chk("s3_cycle_a", acc_c[2], 6);
      chk("s3_port_b", acc_p[3], 1); chk("s3_cycle_b", acc_c[3], 9);
      chk("s3_p0_still_valid", v3[0], 1);

      // reset during a long execution, then replay
      reset3();
      add(0, 0, 5, 0);
      run3(3);
      chk("s4_no_done", ndn, 0);
      reset3();
      add(0, 0, 1, 0); add(0, 1, 1, 0);
      run3(8);
      chk("s4_dones", ndn, 2);
      chk("s4_id", dn_id[1], 1);
      chk("s4_err", er3, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
